// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a free-running tick prescaler,
// a synchronous load, a wrap or hold choice at the terminal value, and
// active-low 7-segment decode with optional leading-zero blanking.
module bcd_updown_counter #(
   parameter int DIGITS   = 2,
   parameter int DIV_EXP  = 22,
   parameter int WRAP     = 1,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [7*DIGITS-1:0]   seg7_out,
   output logic                  tc,
   output logic                  done
);

   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

   logic                tick;
   logic [4*DIGITS-1:0] stepped;
   logic [4*DIGITS-1:0] clamped;
   logic [4*DIGITS-1:0] term;
   logic                at_term;
   logic                ripple;
   logic [3:0]          dig;
   logic                lz;
   logic [3:0]          sdig;

   // Tick source: the prescaler only gates the count, it never clocks anything.
   generate
      if (DIV_EXP == 0) begin : g_nodiv
         assign tick = 1'b1;
      end else begin : g_div
         logic [DIV_EXP-1:0] pre;
         // Free-running prescaler; tick is asserted while it sits at all-ones.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) pre <= '0;
            else        pre <= pre + 1'b1;
         end
         assign tick = &pre;
      end
   endgenerate

   // Next count after one step; the borrow/carry ripples through all digits
   // so 0..0 down becomes 9..9 and 9..9 up becomes 0..0 naturally.
   always_comb begin
      stepped = '0;
      ripple  = 1'b1;
      dig     = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count_bcd[4*i +: 4];
         if (!ripple) begin
            stepped[4*i +: 4] = dig;
         end else if (up) begin
            if (dig >= 4'd9) begin
               stepped[4*i +: 4] = 4'd0;
            end else begin
               stepped[4*i +: 4] = dig + 4'd1;
               ripple = 1'b0;
            end
         end else begin
            if (dig == 4'd0) begin
               stepped[4*i +: 4] = 4'd9;
            end else begin
               stepped[4*i +: 4] = dig - 4'd1;
               ripple = 1'b0;
            end
         end
      end
   end

   // Load value with non-BCD digits saturated to 9, and the terminal value
   // for the current direction.
   always_comb begin
      clamped = '0;
      term    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
         term[4*i +: 4]    = up ? 4'd9 : 4'd0;
      end
   end

   assign at_term = (count_bcd == term);
   assign done    = (WRAP == 0) ? at_term : 1'b0;

   // Count register: load wins over a tick; in hold mode a terminal count
   // ignores ticks. tc is a one-cycle pulse with the update reaching terminal.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_bcd <= ALL_NINES;
         tc        <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (load) begin
            count_bcd <= clamped;
         end else if (tick && enable && !((WRAP == 0) && at_term)) begin
            count_bcd <= stepped;
            tc        <= (stepped == term);
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Segment decode from the MS digit down; lz stays set while every digit
   // seen so far is zero, which marks the leading zeros to blank.
   always_comb begin
      seg7_out = '1;
      lz       = 1'b1;
      sdig     = 4'd0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         sdig = count_bcd[4*k +: 4];
         if ((BLANK_LZ != 0) && (k != 0) && lz && (sdig == 4'd0))
            seg7_out[7*k +: 7] = 7'b1111111;
         else
            seg7_out[7*k +: 7] = seg7(sdig);
         if (sdig != 4'd0) lz = 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: four counter instances share stimulus; each test task
// inspects the instance whose parameters it exercises.
module tb_bcd_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;

   logic [7:0]  cnt0, cnt1, cnt2, cnt3;
   logic [13:0] seg0, seg1, seg2, seg3;
   logic        tc0, tc1, tc2, tc3;
   logic        done0, done1, done2, done3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Reference: wrapping, no prescale
   bcd_updown_counter #(.DIGITS(2), .DIV_EXP(0), .WRAP(1), .BLANK_LZ(0)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .count_bcd(cnt0), .seg7_out(seg0), .tc(tc0), .done(done0));
   // Hold at terminal
   bcd_updown_counter #(.DIGITS(2), .DIV_EXP(0), .WRAP(0), .BLANK_LZ(0)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .count_bcd(cnt1), .seg7_out(seg1), .tc(tc1), .done(done1));
   // Leading-zero blanking
   bcd_updown_counter #(.DIGITS(2), .DIV_EXP(0), .WRAP(1), .BLANK_LZ(1)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .count_bcd(cnt2), .seg7_out(seg2), .tc(tc2), .done(done2));
   // Prescaled by 8
   bcd_updown_counter #(.DIGITS(2), .DIV_EXP(3), .WRAP(1), .BLANK_LZ(0)) u3 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .count_bcd(cnt3), .seg7_out(seg3), .tc(tc3), .done(done3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; up = 1'b1; enable = 1'b0; load = 1'b0;
      #12;
      vectors++; if (cnt0 !== 8'h99) begin miscompares++; $display("FAIL reset_count got %h want 99", cnt0); end
      vectors++; if (tc0 !== 1'b0) begin miscompares++; $display("FAIL reset_tc got %b want 0", tc0); end
      vectors++; if (seg0 !== {7'b0010000, 7'b0010000}) begin miscompares++; $display("FAIL reset_seg got %b want 00100000010000", seg0); end
      vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done_wrap got %b want 0", done0); end
      vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL reset_done_hold_up got %b want 1", done1); end
      up = 1'b0;
      #1;
      vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done_hold_down got %b want 0", done1); end
      reset = 1'b1;
   endtask

   task automatic test_down_wrap();
      int e;
      logic [7:0] exp;
      e = 99;
      up = 1'b0; enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         e = (e + 99) % 100;
         exp = {4'(e / 10), 4'(e % 10)};
         vectors++; if (cnt0 !== exp) begin miscompares++; $display("FAIL down_count step %0d got %h want %h", i, cnt0, exp); end
         vectors++; if (tc0 !== (e == 0)) begin miscompares++; $display("FAIL down_tc step %0d got %b want %b", i, tc0, (e == 0)); end
      end
   endtask

   task automatic test_borrow();
      up = 1'b0; enable = 1'b1; load = 1'b1; load_val = 8'h10;
      step();
      load = 1'b0;
      vectors++; if (cnt0 !== 8'h10) begin miscompares++; $display("FAIL borrow_load got %h want 10", cnt0); end
      step();
      vectors++; if (cnt0 !== 8'h09) begin miscompares++; $display("FAIL borrow_ripple got %h want 09", cnt0); end
      step();
      vectors++; if (cnt0 !== 8'h08) begin miscompares++; $display("FAIL borrow_next got %h want 08", cnt0); end
   endtask

   task automatic test_load_priority();
      up = 1'b0; enable = 1'b1; load = 1'b1; load_val = 8'h3C;
      step();
      vectors++; if (cnt0 !== 8'h39) begin miscompares++; $display("FAIL load_clamp_lo got %h want 39", cnt0); end
      vectors++; if (tc0 !== 1'b0) begin miscompares++; $display("FAIL load_tc got %b want 0", tc0); end
      load_val = 8'hF0;
      step();
      vectors++; if (cnt0 !== 8'h90) begin miscompares++; $display("FAIL load_clamp_hi got %h want 90", cnt0); end
      load = 1'b0;
   endtask

   task automatic test_up_wrap();
      up = 1'b1; enable = 1'b1; load = 1'b1; load_val = 8'h98;
      step();
      load = 1'b0;
      vectors++; if (cnt0 !== 8'h98) begin miscompares++; $display("FAIL up_load got %h want 98", cnt0); end
      step();
      vectors++; if (cnt0 !== 8'h99 || tc0 !== 1'b1) begin miscompares++; $display("FAIL up_terminal got %h/%b want 99/1", cnt0, tc0); end
      step();
      vectors++; if (cnt0 !== 8'h00 || tc0 !== 1'b0) begin miscompares++; $display("FAIL up_wrap got %h/%b want 00/0", cnt0, tc0); end
      step();
      vectors++; if (cnt0 !== 8'h01) begin miscompares++; $display("FAIL up_after_wrap got %h want 01", cnt0); end
   endtask

   task automatic test_hold();
      int pulses;
      logic [7:0] exp_cnt [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      logic       exp_tc  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       exp_dn  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      pulses = 0;
      up = 1'b0; enable = 1'b1; load = 1'b1; load_val = 8'h02;
      step();
      load = 1'b0;
      vectors++; if (cnt1 !== 8'h02) begin miscompares++; $display("FAIL hold_load got %h want 02", cnt1); end
      for (int i = 0; i < 5; i++) begin
         step();
         if (tc1 === 1'b1) pulses++;
         vectors++;
         if (cnt1 !== exp_cnt[i] || tc1 !== exp_tc[i] || done1 !== exp_dn[i]) begin
            miscompares++;
            $display("FAIL hold_tick %0d got %h/%b/%b want %h/%b/%b", i, cnt1, tc1, done1, exp_cnt[i], exp_tc[i], exp_dn[i]);
         end
      end
      vectors++; if (pulses != 1) begin miscompares++; $display("FAIL hold_tc_count got %0d want 1", pulses); end
      @(negedge clk);
      up = 1'b1;
      #1;
      vectors++; if (done1 !== 1'b0 || cnt1 !== 8'h00) begin miscompares++; $display("FAIL hold_release_pre got %h/%b want 00/0", cnt1, done1); end
      step();
      vectors++; if (cnt1 !== 8'h01 || done1 !== 1'b0) begin miscompares++; $display("FAIL hold_release got %h/%b want 01/0", cnt1, done1); end
   endtask

   task automatic test_blank();
      enable = 1'b0; load = 1'b1; load_val = 8'h05;
      step();
      vectors++; if (seg2 !== {7'b1111111, 7'b0010010}) begin miscompares++; $display("FAIL blank_05 got %b want 11111110010010", seg2); end
      load_val = 8'h00;
      step();
      vectors++; if (seg2 !== {7'b1111111, 7'b1000000}) begin miscompares++; $display("FAIL blank_00 got %b want 11111111000000", seg2); end
      load_val = 8'h50;
      step();
      vectors++; if (seg2 !== {7'b0010010, 7'b1000000}) begin miscompares++; $display("FAIL blank_50 got %b want 00100101000000", seg2); end
      vectors++; if (seg0 !== {7'b0010010, 7'b1000000}) begin miscompares++; $display("FAIL noblank_50 got %b want 00100101000000", seg0); end
      load = 1'b0;
   endtask

   task automatic test_reset_mid();
      up = 1'b0; enable = 1'b1; load = 1'b1; load_val = 8'h01;
      step();
      load = 1'b0;
      step();
      vectors++; if (cnt0 !== 8'h00 || tc0 !== 1'b1) begin miscompares++; $display("FAIL mid_pre got %h/%b want 00/1", cnt0, tc0); end
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (cnt0 !== 8'h99 || tc0 !== 1'b0) begin miscompares++; $display("FAIL mid_reset got %h/%b want 99/0", cnt0, tc0); end
   endtask

   task automatic test_prescaler();
      logic [7:0] exp;
      up = 1'b0; enable = 1'b1; load = 1'b0;
      reset = 1'b1;
      exp = 8'h99;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 8)  exp = 8'h98;
         if (n == 16) exp = 8'h97;
         if (n == 40) exp = 8'h96;
         vectors++; if (cnt3 !== exp) begin miscompares++; $display("FAIL prescale clk %0d got %h want %h", n, cnt3, exp); end
         if (n == 16) enable = 1'b0;
         if (n == 36) enable = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_down_wrap();
      test_borrow();
      test_load_priority();
      test_up_wrap();
      test_hold();
      test_blank();
      test_reset_mid();
      test_prescaler();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits, range 1..8.
REQ-002 SHALL have parameter DIV_EXP, default 22: prescaler width; 0 = count tick every clk.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap at terminal, 0 = hold at terminal.
REQ-004 SHALL have parameter BLANK_LZ, default 0: 1 = blank leading-zero digits on the display.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1: count enable, sampled on tick.
REQ-008 SHALL have port up, input, 1: direction, 1 = count up, 0 = count down.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, 4*DIGITS: BCD preset value, digit 0 in [3:0].
REQ-011 SHALL have port count_bcd, output, 4*DIGITS: registered BCD count.
REQ-012 SHALL have port seg7_out, output, 7*DIGITS: active-low segments per digit, digit k at [7k+6:7k].
REQ-013 SHALL have port tc, output, 1: registered terminal-count pulse.
REQ-014 SHALL have port done, output, 1: held-at-terminal flag.

Function
REQ-015 SHALL free-run a DIV_EXP-bit prescaler every clk, independent of enable and load; tick = prescaler all-ones (DIV_EXP=0: tick constant 1); no derived clocks.
REQ-016 SHALL apply load on any clk with load=1, independent of tick: count_bcd <= load_val, with any digit >9 replaced by 9; tc=0 that cycle.
REQ-017 SHALL give load priority over a simultaneous tick; the tick is discarded.
REQ-018 SHALL, on tick & enable & !load, step the count by exactly 1 in the direction given by up sampled that cycle.
REQ-019 SHALL count down as: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit; ripple completes in the same cycle.
REQ-020 SHALL count up as: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
REQ-021 SHALL define terminal value as all zeros when up=0 and all nines when up=1.
REQ-022 SHALL, with WRAP=1 and the count at terminal, wrap on tick: down from 0..0 to 9..9, up from 9..9 to 0..0.
REQ-023 SHALL, with WRAP=0 and the count at terminal, ignore ticks; only load, reset or a change of up can release the hold.
REQ-024 SHALL assert tc for exactly one clk, registered together with the count update whose new value equals terminal.
REQ-025 SHALL drive done = (WRAP==0) & (count_bcd == terminal for current up); done is combinational from registered state.
REQ-026 SHALL apply a change of up on the next tick; no count change occurs without a tick.
REQ-027 SHALL decode each digit to seg7_out using encoding gfedcba, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, other=1111111.
REQ-028 SHALL, with BLANK_LZ=1, drive 1111111 on every zero digit above the highest non-zero digit; digit 0 is never blanked.

Reset
REQ-029 SHALL, while reset=0, force count_bcd to all nines, prescaler to 0 and tc to 0, asynchronously.
REQ-030 SHALL derive done and seg7_out from the reset state: all digits show 9, and done=1 only if WRAP=0 and up=1.
REQ-031 SHALL, on reset deassertion, place the first tick DIV_EXP-dependent: 2^DIV_EXP-1 clks after release, or the first clk when DIV_EXP=0.
REQ-032 SHALL, on reset asserted mid-count, abandon the count and any pending tc immediately.

Verification (DIGITS=2, DIV_EXP=0)
REQ-033 SHALL cover: reset, then up=0, enable=1 for 100 clks -> count 99, 98, ..., 00, 99; tc high only on the clk count becomes 00.
REQ-034 SHALL cover: load_val=0x10, up=0, one tick -> count 09 (borrow ripple); next tick -> 08.
REQ-035 SHALL cover: WRAP=0, load 02, up=0, 5 ticks -> 01, 00 then hold at 00; done=1; a single tc; set up=1 -> next tick 01, done=0.
REQ-036 SHALL cover: load=1 and tick in the same clk with load_val=0x3C -> count 39, no step applied, tc=0.
REQ-037 SHALL cover: BLANK_LZ=1, count 05 -> digit 1 segs 1111111, digit 0 segs 0010010; count 00 -> digit 0 shows 1000000.
REQ-038 SHALL cover: DIV_EXP=3, enable=1 -> count steps once every 8 clks; enable=0 for 20 clks -> no change, prescaler keeps running.
